commit_sequencer: RTL and testbench

//  Sequences retirement from the reorder-buffer head into the commit stage. Each cycle it checks the ROB head.

---
 rtl/commit_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_commit_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_sequencer.sv
// Retires the reorder-buffer head into the commit stage, with a store handshake and a post-jump flush window.
// Optional performance counters are enabled by defining COMMIT_PERF_CNT_EN.
module commit_sequencer #(
    parameter int                ROB_W      = 4,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                TYPE_W     = 3,
    parameter logic [TYPE_W-1:0] JUMP_TYPE  = TYPE_W'(3),
    parameter int                FLUSH_HOLD = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              head_valid_in,
    input  logic              head_ready_in,
    input  logic              head_store_in,
    input  logic [ROB_W-1:0]  head_rob_pos_in,
    input  logic [4:0]        head_rd_in,
    input  logic [DATA_W-1:0] head_data_in,
    input  logic [TYPE_W-1:0] head_type_in,
    input  logic              head_jump_in,
    input  logic [ADDR_W-1:0] head_jaddr_in,
    output logic              pop_out,
    output logic              commit_valid_out,
    output logic [4:0]        commit_rd_out,
    output logic [ROB_W-1:0]  commit_rob_out,
    output logic [DATA_W-1:0] commit_data_out,
    output logic [TYPE_W-1:0] commit_type_out,
    output logic              commit_jump_out,
    output logic [ADDR_W-1:0] commit_jaddr_out,
    output logic              st_req_out,
    output logic [ROB_W-1:0]  st_rob_out,
    input  logic              st_ack_in,
    output logic              flush_out
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [31:0]       perf_commit_out,
    output logic [31:0]       perf_stall_out
`endif
);

    localparam int CNT_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

    typedef enum logic [1:0] {IDLE, ST_WAIT, FLUSH} state_t;

    state_t              r_state, w_stateNext;
    logic [CNT_W-1:0]    r_flushCnt;
    logic                r_stReq;
    logic [ROB_W-1:0]    r_stRob;

    logic                w_pop, w_commit, w_stReqSet, w_stReqClr, w_flushLoad;
    logic [4:0]          w_commitRd;
    logic [ROB_W-1:0]    w_commitRob;
    logic [DATA_W-1:0]   w_commitData;
    logic [TYPE_W-1:0]   w_commitType;
    logic                w_commitJump;
    logic [ADDR_W-1:0]   w_commitJaddr;

    // The flush counter holds the remaining FLUSH cycles minus one, so exit happens when it reads zero.
    always_comb begin
        w_stateNext   = r_state;
        w_pop         = 1'b0;
        w_commit      = 1'b0;
        w_stReqSet    = 1'b0;
        w_stReqClr    = 1'b0;
        w_flushLoad   = 1'b0;
        w_commitRd    = '0;
        w_commitRob   = '0;
        w_commitData  = '0;
        w_commitType  = '0;
        w_commitJump  = 1'b0;
        w_commitJaddr = '0;
        case (r_state)
            IDLE: begin
                if (head_valid_in && head_ready_in) begin
                    if (head_store_in) begin
                        w_stReqSet  = 1'b1;
                        w_stateNext = ST_WAIT;
                    end else begin
                        w_pop         = 1'b1;
                        w_commit      = 1'b1;
                        w_commitRd    = head_rd_in;
                        w_commitRob   = head_rob_pos_in;
                        w_commitData  = head_data_in;
                        w_commitType  = head_type_in;
                        w_commitJump  = head_jump_in;
                        w_commitJaddr = head_jaddr_in;
                        if ((head_type_in == JUMP_TYPE) && head_jump_in) begin
                            w_flushLoad = 1'b1;
                            w_stateNext = FLUSH;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (r_stReq && st_ack_in) begin
                    w_pop        = 1'b1;
                    w_commit     = 1'b1;
                    w_commitRob  = r_stRob;
                    w_commitType = head_type_in;
                    w_stReqClr   = 1'b1;
                    w_stateNext  = IDLE;
                end
            end
            FLUSH: begin
                if (r_flushCnt == '0) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= IDLE;
            r_flushCnt <= '0;
            r_stReq    <= 1'b0;
            r_stRob    <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_flushLoad) begin
                r_flushCnt <= CNT_W'(FLUSH_HOLD - 1);
            end else if ((r_state == FLUSH) && (r_flushCnt != '0)) begin
                r_flushCnt <= r_flushCnt - 1'b1;
            end
            if (w_stReqSet) begin
                r_stReq <= 1'b1;
                r_stRob <= head_rob_pos_in;
            end else if (w_stReqClr) begin
                r_stReq <= 1'b0;
                r_stRob <= '0;
            end
        end
    end

    // Commit payload is zeroed on idle cycles so downstream never sees stale fields.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            commit_valid_out <= 1'b0;
            commit_rd_out    <= '0;
            commit_rob_out   <= '0;
            commit_data_out  <= '0;
            commit_type_out  <= '0;
            commit_jump_out  <= 1'b0;
            commit_jaddr_out <= '0;
        end else begin
            commit_valid_out <= w_commit;
            commit_rd_out    <= w_commitRd;
            commit_rob_out   <= w_commitRob;
            commit_data_out  <= w_commitData;
            commit_type_out  <= w_commitType;
            commit_jump_out  <= w_commitJump;
            commit_jaddr_out <= w_commitJaddr;
        end
    end

    assign pop_out    = w_pop;
    assign st_req_out = r_stReq;
    assign st_rob_out = r_stRob;
    assign flush_out  = (r_state == FLUSH);

`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] r_perfCommit, r_perfStall;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_perfCommit <= '0;
            r_perfStall  <= '0;
        end else begin
            if (commit_valid_out) begin
                r_perfCommit <= r_perfCommit + 32'd1;
            end
            if (head_valid_in && !w_pop && (r_state != FLUSH)) begin
                r_perfStall <= r_perfStall + 32'd1;
            end
        end
    end

    assign perf_commit_out = r_perfCommit;
    assign perf_stall_out  = r_perfStall;
`endif

endmodule

// File: tb/tb_commit_sequencer.sv
// Self-checking bench for commit_sequencer: per-cycle vector table plus scripted store, jump and reset sequences.
// Commits are predicted into a scoreboard queue when a pop is expected and checked when commit_valid_out appears.
module tb_commit_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        head_valid_in, head_ready_in, head_store_in, head_jump_in, st_ack_in;
    logic [3:0]  head_rob_pos_in;
    logic [4:0]  head_rd_in;
    logic [31:0] head_data_in, head_jaddr_in;
    logic [2:0]  head_type_in;
    logic        pop_out, commit_valid_out, commit_jump_out, st_req_out, flush_out;
    logic [4:0]  commit_rd_out;
    logic [3:0]  commit_rob_out, st_rob_out;
    logic [31:0] commit_data_out, commit_jaddr_out;
    logic [2:0]  commit_type_out;
`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] perf_commit_out, perf_stall_out;
`endif

    commit_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .head_valid_in(head_valid_in), .head_ready_in(head_ready_in),
        .head_store_in(head_store_in), .head_rob_pos_in(head_rob_pos_in),
        .head_rd_in(head_rd_in), .head_data_in(head_data_in),
        .head_type_in(head_type_in), .head_jump_in(head_jump_in),
        .head_jaddr_in(head_jaddr_in), .pop_out(pop_out),
        .commit_valid_out(commit_valid_out), .commit_rd_out(commit_rd_out),
        .commit_rob_out(commit_rob_out), .commit_data_out(commit_data_out),
        .commit_type_out(commit_type_out), .commit_jump_out(commit_jump_out),
        .commit_jaddr_out(commit_jaddr_out), .st_req_out(st_req_out),
        .st_rob_out(st_rob_out), .st_ack_in(st_ack_in), .flush_out(flush_out)
`ifdef COMMIT_PERF_CNT_EN
        , .perf_commit_out(perf_commit_out), .perf_stall_out(perf_stall_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        valid, ready, store, jump, expPop;
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic [31:0] data, jaddr;
        logic [3:0]  rob;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data, jaddr;
        logic [3:0]  rob;
        logic [2:0]  typ;
        logic        jump;
    } commit_t;

    commit_t sbQ[$];
    int      nApplied = 0;
    int      nMiscompares = 0;
    vec_t    vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        head_valid_in   = v.valid;
        head_ready_in   = v.ready;
        head_store_in   = v.store;
        head_type_in    = v.typ;
        head_jump_in    = v.jump;
        head_rd_in      = v.rd;
        head_data_in    = v.data;
        head_rob_pos_in = v.rob;
        head_jaddr_in   = v.jaddr;
    endtask

    task automatic pushCommit(input logic [4:0] rd, input logic [31:0] data, input logic [3:0] rob,
                              input logic [2:0] typ, input logic jump, input logic [31:0] jaddr);
        commit_t c;
        c.rd = rd; c.data = data; c.rob = rob; c.typ = typ; c.jump = jump; c.jaddr = jaddr;
        sbQ.push_back(c);
    endtask

    function automatic vec_t mkVec(input logic valid, input logic ready, input logic store,
                                   input logic [2:0] typ, input logic jump, input logic [4:0] rd,
                                   input logic [31:0] data, input logic [3:0] rob,
                                   input logic [31:0] jaddr, input logic expPop);
        vec_t v;
        v.valid = valid; v.ready = ready; v.store = store; v.typ = typ; v.jump = jump;
        v.rd = rd; v.data = data; v.rob = rob; v.jaddr = jaddr; v.expPop = expPop;
        return v;
    endfunction

    // Scoreboard consumer: every commit_valid_out must match the oldest predicted commit.
    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && commit_valid_out === 1'b1) begin
            if (sbQ.size() == 0) begin
                nApplied++;
                nMiscompares++;
                $display("[TB] FAIL unexpected_commit: got commit_valid_out=1, expected 0 at %0t", $time);
            end else begin
                commit_t e;
                e = sbQ.pop_front();
                checkOutput("commit_rd", 32'(commit_rd_out), 32'(e.rd));
                checkOutput("commit_data", commit_data_out, e.data);
                checkOutput("commit_rob", 32'(commit_rob_out), 32'(e.rob));
                checkOutput("commit_type", 32'(commit_type_out), 32'(e.typ));
                checkOutput("commit_jump", 32'(commit_jump_out), 32'(e.jump));
                checkOutput("commit_jaddr", commit_jaddr_out, e.jaddr);
            end
        end
    end

    initial begin
        vecs[0] = mkVec(1, 1, 0, 3'd0, 0, 5'd5,  32'h1234,     4'd0,  32'h0,   1);
        vecs[1] = mkVec(1, 1, 0, 3'd0, 0, 5'd6,  32'h55,       4'd1,  32'h0,   1);
        vecs[2] = mkVec(1, 0, 0, 3'd0, 0, 5'd7,  32'h77,       4'd2,  32'h0,   0);
        vecs[3] = mkVec(0, 1, 0, 3'd0, 0, 5'd7,  32'h77,       4'd2,  32'h0,   0);
        vecs[4] = mkVec(1, 1, 0, 3'd3, 0, 5'd8,  32'hDEADBEEF, 4'd2,  32'h200, 1);
        vecs[5] = mkVec(1, 1, 0, 3'd1, 1, 5'd9,  32'h99,       4'd3,  32'h300, 1);
        vecs[6] = mkVec(1, 0, 1, 3'd2, 0, 5'd10, 32'hAA,       4'd4,  32'h0,   0);
        vecs[7] = mkVec(1, 1, 0, 3'd5, 0, 5'd31, 32'hFFFFFFFF, 4'd15, 32'h0,   1);

        rst_in = 1'b0;
        st_ack_in = 1'b0;
        applyStimulus(mkVec(0, 0, 0, 3'd0, 0, 5'd0, 32'h0, 4'd0, 32'h0, 0));
        repeat (2) @(negedge clk_in);
        checkOutput("reset_commit_valid", 32'(commit_valid_out), 32'd0);
        checkOutput("reset_st_req", 32'(st_req_out), 32'd0);
        checkOutput("reset_flush", 32'(flush_out), 32'd0);
        checkOutput("reset_pop", 32'(pop_out), 32'd0);
        checkOutput("reset_commit_data", commit_data_out, 32'd0);
        rst_in = 1'b1;

        // Vector table: one head presentation per cycle, all starting from IDLE.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_pop", i), 32'(pop_out), 32'(vecs[i].expPop));
            checkOutput($sformatf("vec%0d_flush", i), 32'(flush_out), 32'd0);
            checkOutput($sformatf("vec%0d_st_req", i), 32'(st_req_out), 32'd0);
            if (vecs[i].expPop)
                pushCommit(vecs[i].rd, vecs[i].data, vecs[i].rob, vecs[i].typ, vecs[i].jump, vecs[i].jaddr);
        end
        @(negedge clk_in);
        head_valid_in = 1'b0;

        // Store handshake: request from the next cycle, ack three cycles later.
        @(negedge clk_in);
        applyStimulus(mkVec(1, 1, 1, 3'd2, 0, 5'd3, 32'hAA, 4'd7, 32'h0, 0));
        #1 checkOutput("st_first_pop", 32'(pop_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            #1;
            checkOutput("st_wait_req", 32'(st_req_out), 32'd1);
            checkOutput("st_wait_rob", 32'(st_rob_out), 32'd7);
            checkOutput("st_wait_pop", 32'(pop_out), 32'd0);
        end
        @(negedge clk_in);
        st_ack_in = 1'b1;
        #1 checkOutput("st_ack_pop", 32'(pop_out), 32'd1);
        pushCommit(5'd0, 32'h0, 4'd7, 3'd2, 1'b0, 32'h0);
        @(negedge clk_in);
        st_ack_in = 1'b0;
        head_valid_in = 1'b0;
        #1 checkOutput("st_req_drop", 32'(st_req_out), 32'd0);

        // Taken jump: two-cycle flush, the next ready head waits it out.
        @(negedge clk_in);
        applyStimulus(mkVec(1, 1, 0, 3'd3, 1, 5'd1, 32'h7, 4'd8, 32'h100, 1));
        #1 checkOutput("jmp_pop", 32'(pop_out), 32'd1);
        pushCommit(5'd1, 32'h7, 4'd8, 3'd3, 1'b1, 32'h100);
        @(negedge clk_in);
        applyStimulus(mkVec(1, 1, 0, 3'd0, 0, 5'd12, 32'h99, 4'd9, 32'h0, 1));
        #1;
        checkOutput("flush1_flush", 32'(flush_out), 32'd1);
        checkOutput("flush1_pop", 32'(pop_out), 32'd0);
        @(negedge clk_in);
        #1;
        checkOutput("flush2_flush", 32'(flush_out), 32'd1);
        checkOutput("flush2_pop", 32'(pop_out), 32'd0);
        @(negedge clk_in);
        #1;
        checkOutput("flush_end_flush", 32'(flush_out), 32'd0);
        checkOutput("flush_end_pop", 32'(pop_out), 32'd1);
        pushCommit(5'd12, 32'h99, 4'd9, 3'd0, 1'b0, 32'h0);
        @(negedge clk_in);
        head_valid_in = 1'b0;

        // Reset while waiting on a store ack, then a late ack must be ignored.
        @(negedge clk_in);
        applyStimulus(mkVec(1, 1, 1, 3'd2, 0, 5'd4, 32'h44, 4'd5, 32'h0, 0));
        @(negedge clk_in);
        #1 checkOutput("rst_pre_req", 32'(st_req_out), 32'd1);
        #2;
        rst_in = 1'b0;
        head_valid_in = 1'b0;
        #1;
        checkOutput("rst_st_req", 32'(st_req_out), 32'd0);
        checkOutput("rst_st_rob", 32'(st_rob_out), 32'd0);
        checkOutput("rst_flush", 32'(flush_out), 32'd0);
        checkOutput("rst_commit_valid", 32'(commit_valid_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        st_ack_in = 1'b1;
        #1 checkOutput("post_rst_ack_pop", 32'(pop_out), 32'd0);
        @(negedge clk_in);
        st_ack_in = 1'b0;
        #1 checkOutput("post_rst_st_req", 32'(st_req_out), 32'd0);

        // Head valid but not ready for four cycles: pure stall.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            applyStimulus(mkVec(1, 0, 0, 3'd0, 0, 5'd2, 32'h22, 4'd6, 32'h0, 0));
            #1 checkOutput("stall_pop", 32'(pop_out), 32'd0);
        end
        @(negedge clk_in);
        head_valid_in = 1'b0;
        #1 checkOutput("stall_commit_valid", 32'(commit_valid_out), 32'd0);
`ifdef COMMIT_PERF_CNT_EN
        checkOutput("perf_stall", perf_stall_out, 32'd4);
        checkOutput("perf_commit", perf_commit_out, 32'd0);
`endif

        repeat (2) @(negedge clk_in);
        #1 checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
        $finish;
    end

endmodule
